// File: rtl/photo_reader_ctrl.sv
// Photoelectric tape reader sequencer: motor control, strobe capture, 2-entry char FIFO.
// Optional PHOTO_CHAR_COUNT_EN adds the CHAR_COUNT per-block character counter.
module photo_reader_ctrl #(
  parameter logic [4:0] STOP_CODE = 5'b10000,
  parameter int SETTLE   = 64,
  parameter int DEADTIME = 32,
  parameter int TIMEOUT  = 4096
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       READ_REQ,
  input  logic       REV_REQ,
  input  logic       ABORT,
  input  logic [4:0] PHOTO,
  input  logic       PHOTO_STROBE,
  input  logic       PHOTO_READER_PERMIT,
  output logic [4:0] CHAR,
  output logic       CHAR_VALID,
  input  logic       CHAR_ACCEPT,
  output logic       PHOTO_READER_FWD,
  output logic       PHOTO_READER_REV,
  output logic       BUSY,
  output logic       BLOCK_DONE,
  output logic       ERR
`ifdef PHOTO_CHAR_COUNT_EN
  ,
  output logic [7:0] CHAR_COUNT
`endif
);

  localparam int DW = $clog2(DEADTIME + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, DEAD, SPINUP, FWD_READ, REV_SEARCH, DRAIN, FAULT
  } state_e;

  state_e        state_q;
  logic [4:0]    photo_s1_q, photo_s2_q;
  logic [2:0]    strb_q;
  logic [4:0]    mem0_q, mem1_q;
  logic [1:0]    cnt_q;
  logic          fwd_q, rev_q, rdir_q, bd_q, err_q, motor_q;
  logic [DW-1:0] dead_q;
  logic [SW-1:0] settle_q;
  logic [TW-1:0] tmo_q;

  logic stb_ev, is_stop, pop, full, moving;
  logic push, tmo_hit, ovf, fault_go, spin_go;

  assign stb_ev   = strb_q[1] & ~strb_q[2];
  assign is_stop  = photo_s2_q == STOP_CODE;
  assign pop      = CHAR_ACCEPT & (cnt_q != 2'd0);
  assign full     = cnt_q == 2'd2;
  assign moving   = state_q inside {SPINUP, FWD_READ, REV_SEARCH};
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1)) & ~stb_ev;
  assign ovf      = (state_q == FWD_READ) & stb_ev & ~is_stop
                    & full & ~pop;
  assign fault_go = moving & (~PHOTO_READER_PERMIT | tmo_hit | ovf);
  assign push     = ~ABORT & (state_q == FWD_READ)
                    & PHOTO_READER_PERMIT & stb_ev & ~is_stop
                    & (~full | pop);
  assign spin_go  = ~ABORT & (state_q == DEAD) & (dead_q == '0);

  // Synchronizers, FIFO storage and motor-off dead-time counter
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      photo_s1_q <= '0;
      photo_s2_q <= '0;
      strb_q     <= '0;
      mem0_q     <= '0;
      mem1_q     <= '0;
      cnt_q      <= '0;
      motor_q    <= 1'b0;
      dead_q     <= '0;
    end else begin
      photo_s1_q <= PHOTO;
      photo_s2_q <= photo_s1_q;
      strb_q     <= {strb_q[1:0], PHOTO_STROBE};
      motor_q    <= fwd_q | rev_q;
      if (motor_q & ~(fwd_q | rev_q))
        dead_q <= DW'(DEADTIME);
      else if (dead_q != '0)
        dead_q <= dead_q - 1'b1;
      if (ABORT) begin
        cnt_q <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (cnt_q == 2'd0) mem0_q <= photo_s2_q;
            else               mem1_q <= photo_s2_q;
            cnt_q <= cnt_q + 1'b1;
          end
          2'b01: begin
            mem0_q <= mem1_q;
            cnt_q  <= cnt_q - 1'b1;
          end
          2'b11: begin
            if (full) begin
              mem0_q <= mem1_q;
              mem1_q <= photo_s2_q;
            end else begin
              mem0_q <= photo_s2_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fwd_q    <= 1'b0;
      rev_q    <= 1'b0;
      rdir_q   <= 1'b0;
      bd_q     <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= '0;
      tmo_q    <= '0;
    end else begin
      bd_q  <= 1'b0;
      tmo_q <= stb_ev ? '0 : tmo_q + 1'b1;
      if (ABORT) begin
        state_q <= IDLE;
        fwd_q   <= 1'b0;
        rev_q   <= 1'b0;
        err_q   <= 1'b0;
      end else if (fault_go) begin
        state_q <= FAULT;
        fwd_q   <= 1'b0;
        rev_q   <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (READ_REQ | REV_REQ) begin
              if (PHOTO_READER_PERMIT) begin
                state_q <= DEAD;
                rdir_q  <= ~READ_REQ;
                err_q   <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          DEAD: begin
            if (spin_go) begin
              state_q  <= SPINUP;
              fwd_q    <= ~rdir_q;
              rev_q    <= rdir_q;
              settle_q <= '0;
              tmo_q    <= '0;
            end
          end
          SPINUP: begin
            if (settle_q == SW'(SETTLE - 1)) begin
              state_q <= rdir_q ? REV_SEARCH : FWD_READ;
              tmo_q   <= '0;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          FWD_READ: begin
            if (stb_ev & is_stop) begin
              fwd_q   <= 1'b0;
              state_q <= DRAIN;
            end
          end
          REV_SEARCH: begin
            if (stb_ev & is_stop) begin
              rev_q   <= 1'b0;
              bd_q    <= 1'b1;
              state_q <= IDLE;
            end
          end
          DRAIN: begin
            if (cnt_q == 2'd0) begin
              bd_q    <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PHOTO_CHAR_COUNT_EN
  logic [7:0] cc_q;

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst)
      cc_q <= '0;
    else if (spin_go)
      cc_q <= '0;
    else if (push & (cc_q != 8'hFF))
      cc_q <= cc_q + 1'b1;
  end

  assign CHAR_COUNT = cc_q;
`endif

  assign CHAR             = mem0_q;
  assign CHAR_VALID       = cnt_q != 2'd0;
  assign PHOTO_READER_FWD = fwd_q;
  assign PHOTO_READER_REV = rev_q;
  assign BUSY             = state_q != IDLE;
  assign BLOCK_DONE       = bd_q;
  assign ERR              = err_q;

endmodule
